uart_tx_fifo: RTL
=================

Name: uart_tx_fifo

Overview:
- Parametrised successor to the single-byte async transmitter.
- Buffers words in an internal FIFO, so the host need not wait for each frame to finish.
- Serialises each word with configurable data width, parity mode and stop-bit count, using an internal baud divisor.
- Sits between fabric logic and the board TX pin; one instance per serial channel.

Parameters:
CLK_FREQ, 12000000, input clock frequency in Hz
BAUD, 9600, line rate in bit/s; DIV = (CLK_FREQ + BAUD/2) / BAUD cycles per bit; elaboration error if DIV < 2
DATA_BITS, 8, data bits per frame, legal 5..8, sent LSB first
PARITY, 0, 0 = none, 1 = odd, 2 = even; other values are an elaboration error
STOP_BITS, 1, 1 or 2
FIFO_DEPTH, 4, buffered words, power of two, >= 2

Ports:
clk  in  1  single system clock
rst_n  in  1  asynchronous active-low reset
wr_en  in  1  write strobe; accepted iff full==0
wr_data  in  DATA_BITS  word to transmit
full  out  1  FIFO holds FIFO_DEPTH words
level  out  $clog2(FIFO_DEPTH+1)  words currently in FIFO
overflow  out  1  sticky; set by wr_en while full
clr_ovf  in  1  clears overflow
busy  out  1  FSM not IDLE, or level != 0
tx  out  1  serial line, registered, idle high

Behaviour:
- Reset (async assert, sync release): tx=1, busy=0, full=0, level=0, overflow=0, FSM=IDLE, baud counter=0, FIFO emptied. A reset mid-frame drives tx high at once; the frame is abandoned.
- FIFO: a write is accepted only when full==0, with no full-bypass. Write and pop in the same cycle leave level unchanged. A write while full is dropped and sets overflow. If clr_ovf and a dropped write coincide, overflow=1 (set wins).
- Baud counter: runs only when FSM != IDLE and restarts at 0 on entering START. tick = (counter == DIV-1), then wraps to 0. Every bit lasts exactly DIV cycles.
- FSM states: IDLE -> START -> DATA (DATA_BITS bits) -> PARITY (skipped if PARITY=0) -> STOP (STOP_BITS bits) -> IDLE or START.
- IDLE: if level != 0, pop the head into the shift register, compute the parity bit, go to START.
- START: tx=0. On tick, go to DATA.
- DATA: tx = shift[0]. Shift right on each tick; after DATA_BITS ticks, go to PARITY or STOP.
- PARITY: tx = XOR of the data for even parity, inverted for odd.
- STOP: tx=1. On the final stop tick, if level != 0, pop and go straight to START (no idle gap); else go to IDLE.
- Latency: a write accepted at edge N into an empty FIFO with FSM IDLE is popped at edge N+1. tx goes low at edge N+2, because tx is registered from state.
- Frame length: (1 + DATA_BITS + (PARITY != 0) + STOP_BITS) * DIV cycles.
- Unused upper data bits do not exist, since the width equals DATA_BITS.

Optional Feature:
UART_TX_BREAK_EN
- Defined: adds input port brk (1 bit).
- While brk=1 and FSM is IDLE, tx is held 0 and no pop occurs.
- brk asserted mid-frame takes effect only after the current frame reaches IDLE.
- After brk falls, tx returns to 1 and pending words start no earlier than the next cycle.
- busy is also 1 while brk=1.
- Undefined: no brk port; behaviour exactly as above.

Test Plan:
- Set CLK_FREQ=12000000, BAUD=1000000 (DIV=12), 8N1, and write 0x55 -> tx low 2 cycles after the write. Then 10 bits of 12 cycles each: 0,1,0,1,0,1,0,1,0,1. busy drops after 120 cycles of frame.
- PARITY=2, write 0x07 -> parity bit 1; with PARITY=1 -> parity bit 0. Frame length 11*12 = 132 cycles.
- DATA_BITS=5, STOP_BITS=2, write 0x1F -> start, five 1s, two stop bits. Total 8*12 = 96 cycles.
- Write 0xA1, 0xB2, 0xC3, 0xD4 on consecutive cycles -> four contiguous frames with no idle gap. busy high for 480 frame cycles. level peaks at 3.
- FIFO_DEPTH=4, writes on 6 consecutive cycles -> writes 1-5 accepted (the first is popped at the second edge), write 6 dropped. full=1, overflow=1. clr_ovf clears overflow; the 5 frames still transmit correctly.
- Assert rst_n=0 in the middle of bit 3 of a frame -> tx=1 immediately, level=0. After release, tx stays idle high with no spurious frame.

Source files
------------

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx_fifo
// Purpose  : Buffered asynchronous serial transmitter. Words written by the
//            host are queued in a small FIFO and sent as frames of
//            start / DATA_BITS data (LSB first) / optional parity /
//            STOP_BITS stop bits. Each bit lasts DIV clock cycles, where
//            DIV = round(CLK_FREQ / BAUD).
// Ports    : clk      - system clock
//            rst_n    - asynchronous active-low reset
//            wr_en    - write strobe, accepted only while full == 0
//            wr_data  - word to transmit (DATA_BITS wide)
//            clr_ovf  - clears the sticky overflow flag
//            full     - FIFO holds FIFO_DEPTH words
//            level    - number of words currently queued
//            overflow - sticky, set by a write attempted while full
//            busy     - frame in progress or words pending
//            tx       - registered serial output, idles high
//            brk      - (UART_TX_BREAK_EN only) hold the line low while idle
// Options  : `define UART_TX_BREAK_EN adds the brk input.
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 12000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              wr_en,
  input  logic [DATA_BITS-1:0]              wr_data,
`ifdef UART_TX_BREAK_EN
  input  logic                              brk,
`endif
  input  logic                              clr_ovf,
  output logic                              full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   level,
  output logic                              overflow,
  output logic                              busy,
  output logic                              tx
);

  localparam int   DIV   = (CLK_FREQ + BAUD / 2) / BAUD;
  localparam int   CNT_W = (DIV > 2) ? $clog2(DIV) : 1;
  localparam int   AW    = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int   LW    = $clog2(FIFO_DEPTH + 1);
  localparam logic ODD   = (PARITY == 1);

  // Elaboration-time parameter checks
  generate
    if (DIV < 2) begin : g_err_div
      $error("uart_tx_fifo: baud divisor must be at least 2");
    end
    if (DATA_BITS < 5 || DATA_BITS > 8) begin : g_err_data_bits
      $error("uart_tx_fifo: DATA_BITS must be 5..8");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_err_parity
      $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_err_stop_bits
      $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_err_depth
      $error("uart_tx_fifo: FIFO_DEPTH must be a power of two >= 2");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [LW-1:0]        count;
  logic                 wr_ok;
  logic                 pop;
  logic                 brk_hold;

`ifdef UART_TX_BREAK_EN
  assign brk_hold = brk;
`else
  assign brk_hold = 1'b0;
`endif

  // No full-bypass: a write while full is dropped even if a pop coincides.
  assign full  = (count == LW'(FIFO_DEPTH));
  assign wr_ok = wr_en && !full;
  assign level = count;

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      if (wr_ok && !pop) begin
        count <= count + LW'(1);
      end else if (!wr_ok && pop) begin
        count <= count - LW'(1);
      end
      // A dropped write wins over a simultaneous clear.
      if (wr_en && full) begin
        overflow <= 1'b1;
      end else if (clr_ovf) begin
        overflow <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Frame FSM
  // --------------------------------------------------------------------------
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               state;
  state_t               state_nxt;
  logic [CNT_W-1:0]     baud_cnt;
  logic                 tick;
  logic [2:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift;
  logic                 par_bit;
  logic                 tx_nxt;

  assign tick = (state != S_IDLE) && (baud_cnt == CNT_W'(DIV - 1));
  assign busy = (state != S_IDLE) || (count != '0) || brk_hold;

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    tx_nxt    = 1'b1;
    case (state)
      S_IDLE: begin
        tx_nxt = !brk_hold;
        if (count != '0 && !brk_hold) begin
          pop       = 1'b1;
          state_nxt = S_START;
        end
      end
      S_START: begin
        tx_nxt = 1'b0;
        if (tick) state_nxt = S_DATA;
      end
      S_DATA: begin
        tx_nxt = shift[0];
        if (tick && bit_cnt == 3'(DATA_BITS - 1)) begin
          state_nxt = (PARITY != 0) ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        tx_nxt = par_bit;
        if (tick) state_nxt = S_STOP;
      end
      S_STOP: begin
        tx_nxt = 1'b1;
        if (tick && bit_cnt == 3'(STOP_BITS - 1)) begin
          // Back-to-back frames: chain straight into the next start bit.
          if (count != '0 && !brk_hold) begin
            pop       = 1'b1;
            state_nxt = S_START;
          end else begin
            state_nxt = S_IDLE;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state <= state_nxt;
      // tx follows the current state one cycle later (glitch-free pin).
      tx    <= tx_nxt;
      // Counter wraps on every tick, so each new state starts at 0.
      if (state == S_IDLE || tick) begin
        baud_cnt <= '0;
      end else begin
        baud_cnt <= baud_cnt + CNT_W'(1);
      end
      if (state_nxt != state) begin
        bit_cnt <= '0;
      end else if (tick) begin
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (pop) begin
        shift   <= mem[rd_ptr];
        par_bit <= (^mem[rd_ptr]) ^ ODD;
      end else if (state == S_DATA && tick) begin
        shift <= shift >> 1;
      end
    end
  end

endmodule
`default_nettype wire
